point_sequencer: RTL and testbench
==================================

// Module: point_sequencer
// PURPOSE
//  Upstream feeder for the collisions stage. Holds the state of every soft-body point
//  (pos/vel) of the squishy car, computes a per-point acceleration (ring spring + gravity)
//  from a frame-start snapshot, drives one collisions update per point and writes results
//  back. The renderer reads positions through a combinational read port.
// PARAMETERS
//  NUM_POINTS        4    points in the body ring (>=3)
//  POSITION_SIZE     8    signed position width
//  VELOCITY_SIZE     8    signed velocity width
//  ACCELERATION_SIZE 8    signed acceleration width
//  K_SHIFT           2    spring constant = 2^-K_SHIFT (arithmetic right shift)
//  GRAV_X            0    signed gravity x term added to every point
//  GRAV_Y           -1    signed gravity y term added to every point
//  TIMEOUT        1024    max cycles waiting for coll_result_in per point
// PORTS
//  clk_in            in   1     system clock
//  rst_in            in   1     asynchronous, active-low reset
//  frame_in          in   1     1-cycle pulse: start one physics step
//  load_in           in   1     write load_pos_* into point load_idx_in; its vel := 0
//  load_idx_in       in   $clog2(NUM_POINTS)  point index for load
//  load_pos_x_in/_y_in in POSITION_SIZE  initial position
//  coll_begin_out    out  1     1-cycle start pulse to collisions
//  coll_pos_x_out/_y_out out POSITION_SIZE  current point position
//  coll_vel_x_out/_y_out out VELOCITY_SIZE  current point velocity
//  coll_accel_x_out/_y_out out ACCELERATION_SIZE  computed acceleration
//  coll_result_in    in   1     collisions result valid (level)
//  coll_new_pos_x_in/_y_in in POSITION_SIZE  updated position
//  coll_new_vel_x_in/_y_in in VELOCITY_SIZE  updated velocity
//  rd_idx_in         in   $clog2(NUM_POINTS)  renderer read index
//  rd_pos_x_out/_y_out out POSITION_SIZE  combinational read of stored position
//  busy_out          out  1     high from accepted frame_in until step done
//  step_done_out     out  1     1-cycle pulse when all points written
//  timeout_out       out  1     sticky: a point exceeded TIMEOUT; cleared only by reset
// BEHAVIOUR
//  Reset (rst_in=0, async): all pos/vel/accel regs 0, FSM IDLE, every output 0.
//  FSM: IDLE -> ACCEL (frame_in) -> ISSUE -> WAIT -> WRITE -> ISSUE (next) | DONE -> IDLE.
//  ACCEL: NUM_POINTS cycles, one point i per cycle, all from the frame-start positions:
//   ax = sat((x[i-1]+x[i+1]-2*x[i]) >>> K_SHIFT + GRAV_X), same for y; indices wrap mod N.
//   Intermediates POSITION_SIZE+3 bits signed; sat clamps to ACCELERATION_SIZE range.
//   Positions are not modified during ACCEL (snapshot = live regs, untouched until WRITE).
//  ISSUE: coll_* data outputs show point i; coll_begin_out=1 for exactly this cycle.
//   Data outputs held stable from ISSUE through WAIT.
//  WAIT: result accepted only when coll_result_in=1 after being seen 0 at least once
//   since ISSUE (edge-qualified; stale level from the previous point is ignored).
//   Wait counter > TIMEOUT: timeout_out:=1, point i keeps old state, go to WRITE-skip.
//  WRITE: 1 cycle, latch coll_new_* into point i; i++ ; i==N-1 -> DONE.
//  DONE: step_done_out=1 for 1 cycle, busy_out falls next cycle.
//  Latency: frame_in -> step_done_out = 1 + N + sum_i(1 + wait_i + 1) cycles.
//  frame_in while busy_out=1: ignored (no queueing). load_in honoured only in IDLE;
//  load_in and frame_in together in IDLE: load wins this cycle, frame_in dropped.
//  coll_result_in outside WAIT: ignored. rd port always live, reads mid-step values.
//  Reset mid-step: returns to IDLE immediately, all state zeroed, no done pulse.
// STRUCTURE
//  physics_pkg: FSM state enum, sat_signed() function, index-wrap helper.
//  Sub-module spring_accel: combinational (prev,cur,next,grav) -> saturated accel, one
//  instance per axis; point_sequencer owns the register arrays, FSM and counters.
// TESTING
//  Square N=4 (-10,-10),(10,-10),(10,10),(-10,10), vel 0, frame -> point0 accel (5,4),
//   point1 accel (-5,4); coll_begin_out pulses exactly 4 times; step_done_out once.
//  Stub collisions returning pos+vel+accel after 3 cycles, result held high between
//   points -> each point accepted only after fresh 0->1; final pos0 = (-5,-6).
//  Saturation: N=3 points x=(-128,127,-128), K_SHIFT=0 -> point1 ax clamps to -128.
//  Stub never raises result, TIMEOUT=16 -> timeout_out=1 sticky, point states unchanged,
//   step_done_out still pulses after 4 timeouts.
//  frame_in re-pulsed while busy and load_in during step -> no effect on count/state;
//   load_in+frame_in in IDLE -> load applied, no step started.
//  rst_in low in WAIT -> all outputs 0 next sample, busy_out 0, no step_done_out.

Source files
------------

// File: rtl/point_sequencer_pkg.sv
// Shared types and helpers for the soft-body point sequencer.
// Provides the FSM state encoding, signed saturation and ring-index wrapping.
package point_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAccel,
        StIssue,
        StWait,
        StWrite,
        StDone
    } state_e;

    // Clamp a signed value into the range of a width-bit two's complement number.
    function automatic int sat_signed(input int value, input int unsigned width);
        int hi;
        int lo;
        hi = (1 << (width - 1)) - 1;
        lo = -hi - 1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // Wrap an index that is at most one step outside [0, n).
    function automatic int wrap_idx(input int idx, input int n);
        if (idx < 0) begin
            return idx + n;
        end else if (idx >= n) begin
            return idx - n;
        end
        return idx;
    endfunction

endpackage

// File: rtl/point_sequencer_spring_accel.sv
// Combinational ring-spring acceleration for one axis of one point:
// sat(((prev + next - 2*cur) >>> K_SHIFT) + GRAV).
module point_sequencer_spring_accel
    import point_sequencer_pkg::*;
#(
    parameter int POSITION_SIZE     = 8,
    parameter int ACCELERATION_SIZE = 8,
    parameter int K_SHIFT           = 2,
    parameter int GRAV              = 0
) (
    input  logic signed [POSITION_SIZE-1:0]     prev_pos,
    input  logic signed [POSITION_SIZE-1:0]     cur_pos,
    input  logic signed [POSITION_SIZE-1:0]     next_pos,
    output logic signed [ACCELERATION_SIZE-1:0] accel
);

    // Three guard bits hold the worst case of prev + next - 2*cur without overflow.
    localparam int W = POSITION_SIZE + 3;

    logic signed [W-1:0] prev_ext;
    logic signed [W-1:0] cur_ext;
    logic signed [W-1:0] next_ext;
    logic signed [W-1:0] lap;
    logic signed [W-1:0] scaled;
    logic signed [W-1:0] biased;

    always_comb begin
        prev_ext = {{3{prev_pos[POSITION_SIZE-1]}}, prev_pos};
        cur_ext  = {{3{cur_pos[POSITION_SIZE-1]}}, cur_pos};
        next_ext = {{3{next_pos[POSITION_SIZE-1]}}, next_pos};
        lap      = prev_ext + next_ext - (cur_ext <<< 1);
        scaled   = lap >>> K_SHIFT;
        biased   = scaled + W'(GRAV);
        accel    = ACCELERATION_SIZE'(sat_signed(int'(biased), ACCELERATION_SIZE));
    end

endmodule

// File: rtl/point_sequencer.sv
// Soft-body point store and step sequencer: computes per-point spring+gravity
// acceleration from a frame-start snapshot, then hands each point to collisions.
module point_sequencer
    import point_sequencer_pkg::*;
#(
    parameter int NUM_POINTS        = 4,
    parameter int POSITION_SIZE     = 8,
    parameter int VELOCITY_SIZE     = 8,
    parameter int ACCELERATION_SIZE = 8,
    parameter int K_SHIFT           = 2,
    parameter int GRAV_X            = 0,
    parameter int GRAV_Y            = -1,
    parameter int TIMEOUT           = 1024
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  frame_in,
    input  logic                                  load_in,
    input  logic [$clog2(NUM_POINTS)-1:0]         load_idx_in,
    input  logic signed [POSITION_SIZE-1:0]       load_pos_x_in,
    input  logic signed [POSITION_SIZE-1:0]       load_pos_y_in,
    output logic                                  coll_begin_out,
    output logic signed [POSITION_SIZE-1:0]       coll_pos_x_out,
    output logic signed [POSITION_SIZE-1:0]       coll_pos_y_out,
    output logic signed [VELOCITY_SIZE-1:0]       coll_vel_x_out,
    output logic signed [VELOCITY_SIZE-1:0]       coll_vel_y_out,
    output logic signed [ACCELERATION_SIZE-1:0]   coll_accel_x_out,
    output logic signed [ACCELERATION_SIZE-1:0]   coll_accel_y_out,
    input  logic                                  coll_result_in,
    input  logic signed [POSITION_SIZE-1:0]       coll_new_pos_x_in,
    input  logic signed [POSITION_SIZE-1:0]       coll_new_pos_y_in,
    input  logic signed [VELOCITY_SIZE-1:0]       coll_new_vel_x_in,
    input  logic signed [VELOCITY_SIZE-1:0]       coll_new_vel_y_in,
    input  logic [$clog2(NUM_POINTS)-1:0]         rd_idx_in,
    output logic signed [POSITION_SIZE-1:0]       rd_pos_x_out,
    output logic signed [POSITION_SIZE-1:0]       rd_pos_y_out,
    output logic                                  busy_out,
    output logic                                  step_done_out,
    output logic                                  timeout_out
);

    localparam int IDX_W = $clog2(NUM_POINTS);
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

    logic signed [POSITION_SIZE-1:0]     pos_x_q   [NUM_POINTS];
    logic signed [POSITION_SIZE-1:0]     pos_y_q   [NUM_POINTS];
    logic signed [VELOCITY_SIZE-1:0]     vel_x_q   [NUM_POINTS];
    logic signed [VELOCITY_SIZE-1:0]     vel_y_q   [NUM_POINTS];
    logic signed [ACCELERATION_SIZE-1:0] accel_x_q [NUM_POINTS];
    logic signed [ACCELERATION_SIZE-1:0] accel_y_q [NUM_POINTS];

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               seen_low_q, seen_low_d;
    logic               accepted_q, accepted_d;
    logic               timeout_q, timeout_d;

    logic               load_en;
    logic               accel_en;
    logic               write_en;
    logic [IDX_W-1:0]   prev_idx;
    logic [IDX_W-1:0]   next_idx;
    logic signed [ACCELERATION_SIZE-1:0] accel_x;
    logic signed [ACCELERATION_SIZE-1:0] accel_y;

    always_comb begin
        prev_idx = IDX_W'(wrap_idx(int'(idx_q) - 1, NUM_POINTS));
        next_idx = IDX_W'(wrap_idx(int'(idx_q) + 1, NUM_POINTS));
    end

    point_sequencer_spring_accel #(
        .POSITION_SIZE     (POSITION_SIZE),
        .ACCELERATION_SIZE (ACCELERATION_SIZE),
        .K_SHIFT           (K_SHIFT),
        .GRAV              (GRAV_X)
    ) u_accel_x (
        .prev_pos (pos_x_q[prev_idx]),
        .cur_pos  (pos_x_q[idx_q]),
        .next_pos (pos_x_q[next_idx]),
        .accel    (accel_x)
    );

    point_sequencer_spring_accel #(
        .POSITION_SIZE     (POSITION_SIZE),
        .ACCELERATION_SIZE (ACCELERATION_SIZE),
        .K_SHIFT           (K_SHIFT),
        .GRAV              (GRAV_Y)
    ) u_accel_y (
        .prev_pos (pos_y_q[prev_idx]),
        .cur_pos  (pos_y_q[idx_q]),
        .next_pos (pos_y_q[next_idx]),
        .accel    (accel_y)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            wait_cnt_q <= '0;
            seen_low_q <= 1'b0;
            accepted_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            seen_low_q <= seen_low_d;
            accepted_q <= accepted_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        seen_low_d = seen_low_q;
        accepted_d = accepted_q;
        timeout_d  = timeout_q;
        load_en    = 1'b0;
        accel_en   = 1'b0;
        write_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A load in the same cycle as a frame request takes priority.
                if (load_in) begin
                    load_en = (int'(load_idx_in) < NUM_POINTS);
                end else if (frame_in) begin
                    state_d = StAccel;
                    idx_d   = '0;
                end
            end
            StAccel: begin
                accel_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = StIssue;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StIssue: begin
                wait_cnt_d = '0;
                seen_low_d = !coll_result_in;
                accepted_d = 1'b0;
                state_d    = StWait;
            end
            StWait: begin
                seen_low_d = seen_low_q | !coll_result_in;
                // Only a fresh rising result counts; a level left over from the
                // previous point is ignored until it has dropped at least once.
                if (coll_result_in && seen_low_q) begin
                    accepted_d = 1'b1;
                    state_d    = StWrite;
                end else if (wait_cnt_q >= CNT_W'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = StWrite;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            StWrite: begin
                write_en = accepted_q;
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = StIssue;
                end
            end
            StDone: begin
                idx_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                pos_x_q[i]   <= '0;
                pos_y_q[i]   <= '0;
                vel_x_q[i]   <= '0;
                vel_y_q[i]   <= '0;
                accel_x_q[i] <= '0;
                accel_y_q[i] <= '0;
            end
        end else begin
            if (load_en) begin
                pos_x_q[load_idx_in] <= load_pos_x_in;
                pos_y_q[load_idx_in] <= load_pos_y_in;
                vel_x_q[load_idx_in] <= '0;
                vel_y_q[load_idx_in] <= '0;
            end
            if (accel_en) begin
                accel_x_q[idx_q] <= accel_x;
                accel_y_q[idx_q] <= accel_y;
            end
            if (write_en) begin
                pos_x_q[idx_q] <= coll_new_pos_x_in;
                pos_y_q[idx_q] <= coll_new_pos_y_in;
                vel_x_q[idx_q] <= coll_new_vel_x_in;
                vel_y_q[idx_q] <= coll_new_vel_y_in;
            end
        end
    end

    always_comb begin
        coll_begin_out   = (state_q == StIssue);
        busy_out         = (state_q != StIdle);
        step_done_out    = (state_q == StDone);
        timeout_out      = timeout_q;
        coll_pos_x_out   = pos_x_q[idx_q];
        coll_pos_y_out   = pos_y_q[idx_q];
        coll_vel_x_out   = vel_x_q[idx_q];
        coll_vel_y_out   = vel_y_q[idx_q];
        coll_accel_x_out = accel_x_q[idx_q];
        coll_accel_y_out = accel_y_q[idx_q];
        rd_pos_x_out     = '0;
        rd_pos_y_out     = '0;
        if (int'(rd_idx_in) < NUM_POINTS) begin
            rd_pos_x_out = pos_x_q[rd_idx_in];
            rd_pos_y_out = pos_y_q[rd_idx_in];
        end
    end

endmodule

// File: tb/tb_point_sequencer.sv
// Scoreboard bench for point_sequencer: a behavioural ring model predicts every
// collisions request and the stored positions after each physics step.
module tb_point_sequencer;

    localparam int N  = 4;
    localparam int KS = 2;
    localparam int GX = 0;
    localparam int GY = -1;
    localparam int TO = 16;

    typedef struct {
        int px;
        int py;
        int vx;
        int vy;
        int ax;
        int ay;
    } issue_t;

    logic clk;
    logic rst_n;

    // Main instance (square ring, N=4)
    logic              frame, load;
    logic [1:0]        load_idx, rd_idx;
    logic signed [7:0] load_x, load_y;
    logic              coll_begin, coll_result;
    logic signed [7:0] cpx, cpy, cvx, cvy, cax, cay;
    logic signed [7:0] npx, npy, nvx, nvy;
    logic signed [7:0] rd_x, rd_y;
    logic              busy, done, tmo;

    // Saturation instance (N=3, K_SHIFT=0), collisions never answers
    logic              s_frame, s_load, s_result;
    logic [1:0]        s_load_idx, s_rd_idx;
    logic signed [7:0] s_load_x, s_load_y;
    logic              s_begin, s_busy, s_done, s_tmo;
    logic signed [7:0] s_cpx, s_cpy, s_cvx, s_cvy, s_cax, s_cay;
    logic signed [7:0] s_rd_x, s_rd_y;
    logic signed [7:0] s_zero;

    int n_vec = 0;
    int n_err = 0;
    int begin_cnt = 0;
    int done_cnt = 0;
    int stub_mode = 0;

    int mx[N], my[N], mvx[N], mvy[N];
    issue_t exp_q[$];
    int obs_ax[$], obs_ay[$];
    int s_obs_ax[$], s_obs_ay[$];

    point_sequencer #(
        .NUM_POINTS(N), .POSITION_SIZE(8), .VELOCITY_SIZE(8), .ACCELERATION_SIZE(8),
        .K_SHIFT(KS), .GRAV_X(GX), .GRAV_Y(GY), .TIMEOUT(TO)
    ) u_dut (
        .clk_in(clk), .rst_in(rst_n), .frame_in(frame), .load_in(load),
        .load_idx_in(load_idx), .load_pos_x_in(load_x), .load_pos_y_in(load_y),
        .coll_begin_out(coll_begin), .coll_pos_x_out(cpx), .coll_pos_y_out(cpy),
        .coll_vel_x_out(cvx), .coll_vel_y_out(cvy),
        .coll_accel_x_out(cax), .coll_accel_y_out(cay),
        .coll_result_in(coll_result), .coll_new_pos_x_in(npx), .coll_new_pos_y_in(npy),
        .coll_new_vel_x_in(nvx), .coll_new_vel_y_in(nvy),
        .rd_idx_in(rd_idx), .rd_pos_x_out(rd_x), .rd_pos_y_out(rd_y),
        .busy_out(busy), .step_done_out(done), .timeout_out(tmo)
    );

    point_sequencer #(
        .NUM_POINTS(3), .POSITION_SIZE(8), .VELOCITY_SIZE(8), .ACCELERATION_SIZE(8),
        .K_SHIFT(0), .GRAV_X(0), .GRAV_Y(-1), .TIMEOUT(TO)
    ) u_sat (
        .clk_in(clk), .rst_in(rst_n), .frame_in(s_frame), .load_in(s_load),
        .load_idx_in(s_load_idx), .load_pos_x_in(s_load_x), .load_pos_y_in(s_load_y),
        .coll_begin_out(s_begin), .coll_pos_x_out(s_cpx), .coll_pos_y_out(s_cpy),
        .coll_vel_x_out(s_cvx), .coll_vel_y_out(s_cvy),
        .coll_accel_x_out(s_cax), .coll_accel_y_out(s_cay),
        .coll_result_in(s_result), .coll_new_pos_x_in(s_zero), .coll_new_pos_y_in(s_zero),
        .coll_new_vel_x_in(s_zero), .coll_new_vel_y_in(s_zero),
        .rd_idx_in(s_rd_idx), .rd_pos_x_out(s_rd_x), .rd_pos_y_out(s_rd_y),
        .busy_out(s_busy), .step_done_out(s_done), .timeout_out(s_tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int wrap8(input int v);
        int r;
        r = v & 255;
        if (r > 127) r -= 256;
        return r;
    endfunction

    function automatic int m_accel(input int p, input int c, input int n, input int g,
                                   input int k);
        int v;
        v = ((p + n - 2 * c) >>> k) + g;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Reference: accelerations from the snapshot, then pos += vel + acc, vel += acc.
    task automatic model_step(input int mode);
        int ax[N];
        int ay[N];
        issue_t e;
        for (int i = 0; i < N; i++) begin
            int p;
            int q;
            p = (i + N - 1) % N;
            q = (i + 1) % N;
            ax[i] = m_accel(mx[p], mx[i], mx[q], GX, KS);
            ay[i] = m_accel(my[p], my[i], my[q], GY, KS);
            e.px = mx[i]; e.py = my[i]; e.vx = mvx[i]; e.vy = mvy[i];
            e.ax = ax[i]; e.ay = ay[i];
            exp_q.push_back(e);
        end
        if (mode == 0) begin
            for (int i = 0; i < N; i++) begin
                mx[i]  = wrap8(mx[i] + mvx[i] + ax[i]);
                my[i]  = wrap8(my[i] + mvy[i] + ay[i]);
                mvx[i] = wrap8(mvx[i] + ax[i]);
                mvy[i] = wrap8(mvy[i] + ay[i]);
            end
        end
    endtask

    // Collisions stub: keeps the previous result level for a few cycles (stale),
    // then drops it and raises it again with pos+vel+acc, vel+acc.
    initial begin
        int px, py, vx, vy, ax, ay, hold, dly;
        coll_result = 1'b0;
        npx = '0; npy = '0; nvx = '0; nvy = '0;
        forever begin
            @(negedge clk);
            if (rst_n && coll_begin) begin
                px = cpx; py = cpy; vx = cvx; vy = cvy; ax = cax; ay = cay;
                if (stub_mode == 0) begin
                    hold = $urandom_range(0, 2);
                    dly  = $urandom_range(1, 4);
                    repeat (hold) @(negedge clk);
                    coll_result = 1'b0;
                    repeat (dly) @(negedge clk);
                    npx = 8'(px + vx + ax);
                    npy = 8'(py + vy + ay);
                    nvx = 8'(vx + ax);
                    nvy = 8'(vy + ay);
                    coll_result = 1'b1;
                end else begin
                    coll_result = 1'b0;
                end
            end
        end
    end

    // Monitor: every collisions request is popped from the scoreboard and compared.
    initial begin
        issue_t e;
        forever begin
            @(negedge clk);
            if (rst_n && coll_begin) begin
                begin_cnt++;
                obs_ax.push_back(int'(cax));
                obs_ay.push_back(int'(cay));
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL issue_unexpected: got request at pos (%0d,%0d), required none",
                             cpx, cpy);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_pos_x", cpx, e.px);
                    check("issue_pos_y", cpy, e.py);
                    check("issue_vel_x", cvx, e.vx);
                    check("issue_vel_y", cvy, e.vy);
                    check("issue_acc_x", cax, e.ax);
                    check("issue_acc_y", cay, e.ay);
                end
            end
            if (rst_n && done) done_cnt++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && s_begin) begin
                s_obs_ax.push_back(int'(s_cax));
                s_obs_ay.push_back(int'(s_cay));
            end
        end
    end

    task automatic load_pt(input int i, input int x, input int y);
        @(negedge clk);
        load = 1'b1; load_idx = 2'(i); load_x = 8'(x); load_y = 8'(y);
        @(negedge clk);
        load = 1'b0;
        mx[i] = x; my[i] = y; mvx[i] = 0; mvy[i] = 0;
    endtask

    task automatic check_all_pos();
        for (int i = 0; i < N; i++) begin
            rd_idx = 2'(i);
            #1;
            check($sformatf("rd_pos_x[%0d]", i), rd_x, mx[i]);
            check($sformatf("rd_pos_y[%0d]", i), rd_y, my[i]);
        end
    endtask

    task automatic run_step(input int mode, input int interfere);
        int b0, d0, seen;
        stub_mode = mode;
        model_step(mode);
        obs_ax.delete();
        obs_ay.delete();
        b0 = begin_cnt;
        d0 = done_cnt;
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        if (interfere != 0) begin
            repeat (N + 3) @(negedge clk);
            frame = 1'b1; load = 1'b1; load_idx = 2'd0; load_x = 8'sd99; load_y = -8'sd99;
            @(negedge clk);
            frame = 1'b0; load = 1'b0;
        end
        seen = 0;
        for (int c = 0; c < 400 && seen == 0; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("step_done_seen", seen, 1);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        repeat (3) @(negedge clk);
        check("issue_count", begin_cnt - b0, N);
        check("done_count", done_cnt - d0, 1);
        check("scoreboard_drained", exp_q.size(), 0);
        check_all_pos();
    endtask

    initial begin
        int b0, d0, seen;
        rst_n = 1'b0;
        frame = 1'b0; load = 1'b0; load_idx = '0; load_x = '0; load_y = '0; rd_idx = '0;
        s_frame = 1'b0; s_load = 1'b0; s_load_idx = '0; s_load_x = '0; s_load_y = '0;
        s_rd_idx = '0; s_result = 1'b0; s_zero = '0;
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", tmo, 0);
        check("rst_begin", coll_begin, 0);
        check("rst_coll_pos_x", cpx, 0);
        check("rst_coll_acc_y", cay, 0);
        check("rst_rd_x", rd_x, 0);
        check("rst_sat_busy", s_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation on the three-point instance
        begin
            int sx[3];
            int sy[3];
            sx[0] = -128; sx[1] = 127; sx[2] = -128;
            sy[0] = 5;    sy[1] = -3;  sy[2] = 7;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                s_load = 1'b1; s_load_idx = 2'(i); s_load_x = 8'(sx[i]); s_load_y = 8'(sy[i]);
            end
            @(negedge clk);
            s_load = 1'b0; s_frame = 1'b1;
            @(negedge clk);
            s_frame = 1'b0;
            seen = 0;
            for (int c = 0; c < 300 && seen == 0; c++) begin
                @(negedge clk);
                if (s_done) seen = 1;
            end
            check("sat_step_done", seen, 1);
            check("sat_issue_count", s_obs_ax.size(), 3);
            check("sat_timeout", s_tmo, 1);
            if (s_obs_ax.size() == 3) begin
                check("sat_p1_ax_clamp", s_obs_ax[1], -128);
                for (int i = 0; i < 3; i++) begin
                    int p;
                    int q;
                    p = (i + 2) % 3;
                    q = (i + 1) % 3;
                    check($sformatf("sat_ax[%0d]", i), s_obs_ax[i],
                          m_accel(sx[p], sx[i], sx[q], 0, 0));
                    check($sformatf("sat_ay[%0d]", i), s_obs_ay[i],
                          m_accel(sy[p], sy[i], sy[q], -1, 0));
                end
            end
            for (int i = 0; i < 3; i++) begin
                s_rd_idx = 2'(i);
                #1;
                check($sformatf("sat_pos_kept[%0d]", i), s_rd_x, sx[i]);
            end
        end

        // Square ring
        load_pt(0, -10, -10);
        load_pt(1, 10, -10);
        load_pt(2, 10, 10);
        load_pt(3, -10, 10);
        run_step(0, 0);
        check("square_obs_count", obs_ax.size(), N);
        if (obs_ax.size() >= 2) begin
            check("square_p0_ax", obs_ax[0], 5);
            check("square_p0_ay", obs_ay[0], 4);
            check("square_p1_ax", obs_ax[1], -5);
            check("square_p1_ay", obs_ay[1], 4);
        end
        rd_idx = 2'd0;
        #1;
        check("square_final_p0_x", rd_x, -5);
        check("square_final_p0_y", rd_y, -6);
        check("timeout_clear", tmo, 0);

        // Random reloads and steps; one step sees frame/load pulses while busy
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) load_pt(i, rnd8(), rnd8());
            end
            run_step(0, (s == 2) ? 1 : 0);
        end

        // load_in together with frame_in while idle: load only
        b0 = begin_cnt;
        @(negedge clk);
        load = 1'b1; frame = 1'b1; load_idx = 2'd2; load_x = 8'sd33; load_y = -8'sd44;
        @(negedge clk);
        load = 1'b0; frame = 1'b0;
        mx[2] = 33; my[2] = -44; mvx[2] = 0; mvy[2] = 0;
        repeat (6) @(negedge clk);
        check("load_frame_busy", busy, 0);
        check("load_frame_no_issue", begin_cnt - b0, 0);
        check_all_pos();
        run_step(0, 0);

        // Collisions never answers: every point times out, state kept
        run_step(1, 0);
        check("timeout_set", tmo, 1);
        run_step(0, 0);
        check("timeout_sticky", tmo, 1);

        // Reset while waiting on collisions
        stub_mode = 1;
        model_step(1);
        b0 = begin_cnt;
        @(negedge clk);
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        seen = 0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
            @(negedge clk);
            if (begin_cnt > b0) seen = 1;
        end
        check("rstwait_issue_seen", seen, 1);
        repeat (2) @(negedge clk);
        check("rstwait_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rstwait_busy", busy, 0);
        check("rstwait_done", done, 0);
        check("rstwait_timeout", tmo, 0);
        check("rstwait_begin", coll_begin, 0);
        check("rstwait_coll_pos_x", cpx, 0);
        check("rstwait_coll_vel_y", cvy, 0);
        check("rstwait_coll_acc_x", cax, 0);
        check("rstwait_rd_y", rd_y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0;
        end
        d0 = done_cnt;
        repeat (30) @(negedge clk);
        check("rstwait_no_done", done_cnt - d0, 0);
        check("rstwait_idle", busy, 0);
        check_all_pos();

        // Recovery after reset
        for (int i = 0; i < N; i++) load_pt(i, rnd8(), rnd8());
        run_step(0, 0);
        run_step(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
